// File: rtl/if_id_skid_stage.sv
// IF/ID stage register with a 2-entry skid buffer and ready/valid on both sides.
// Optional saturating stall counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_skid_stage #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc4_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc4_out
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  logic               main_v_q, main_v_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
  logic               skid_v_q, skid_v_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
  logic               accept;
  logic               drain;

  assign in_ready  = !skid_v_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_v_q && out_ready;
  assign out_valid = main_v_q;
  assign instr_out = main_instr_q;
  assign pc4_out   = main_pc4_q;

  // Next-state for both entries; flush overrides everything.
  always_comb begin
    main_v_d     = main_v_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if (flush) begin
      main_v_d     = 1'b0;
      main_instr_d = NOP_INSTR;
      main_pc4_d   = pc4_in;
      skid_v_d     = 1'b0;
    end else if (!main_v_q || drain) begin
      if (skid_v_q) begin
        main_v_d     = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc4_d   = skid_pc4_q;
        skid_v_d     = accept;
        if (accept) begin
          skid_instr_d = instr_in;
          skid_pc4_d   = pc4_in;
        end
      end else if (accept) begin
        main_v_d     = 1'b1;
        main_instr_d = instr_in;
        main_pc4_d   = pc4_in;
      end else begin
        main_v_d     = 1'b0;
        main_instr_d = NOP_INSTR;
      end
    end else if (accept) begin
      skid_v_d     = 1'b1;
      skid_instr_d = instr_in;
      skid_pc4_d   = pc4_in;
    end
  end

  // Entry registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_v_q     <= 1'b0;
      main_instr_q <= NOP_INSTR;
      main_pc4_q   <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      main_v_q     <= main_v_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of cycles a valid output waits on decode.
  always_comb begin
    cnt_d = cnt_q;
    if (main_v_q && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; only reset clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed table-driven bench for if_id_skid_stage.
// Covers streaming, stall fill, flush, bubbles, async reset, stall counter.
module tb_if_id_skid_stage;
  localparam int CNT_W = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic [31:0] pc4_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
`ifdef IF_ID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid_stage #(
    .INSTR_W(32),
    .PC_W(32),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr_in(instr_in),
    .pc4_in(pc4_in),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instr_out(instr_out),
    .pc4_out(pc4_out)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_ir;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic ir);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".instr_out"}, instr_out, ins);
    chk({tag, ".pc4_out"}, pc4_out, pc);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, ir});
  endtask

  initial begin
    // stream
    tbl[0]  = '{1, 32'h11, 32'h104, 0, 1, 1, 32'h11, 32'h104, 1};
    tbl[1]  = '{1, 32'h22, 32'h108, 0, 1, 1, 32'h22, 32'h108, 1};
    tbl[2]  = '{1, 32'h33, 32'h10c, 0, 1, 1, 32'h33, 32'h10c, 1};
    // bubble
    tbl[3]  = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h10c, 1};
    tbl[4]  = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h10c, 1};
    // stall fill
    tbl[5]  = '{1, 32'hAA, 32'h200, 0, 0, 1, 32'hAA, 32'h200, 1};
    tbl[6]  = '{1, 32'hBB, 32'h204, 0, 0, 1, 32'hAA, 32'h200, 0};
    tbl[7]  = '{1, 32'hCC, 32'h208, 0, 0, 1, 32'hAA, 32'h200, 0};
    tbl[8]  = '{1, 32'hCC, 32'h208, 0, 0, 1, 32'hAA, 32'h200, 0};
    tbl[9]  = '{1, 32'hCC, 32'h208, 0, 0, 1, 32'hAA, 32'h200, 0};
    tbl[10] = '{1, 32'hCC, 32'h208, 0, 1, 1, 32'hBB, 32'h204, 1};
    tbl[11] = '{1, 32'hCC, 32'h208, 0, 1, 1, 32'hCC, 32'h208, 1};
    tbl[12] = '{0, 32'h0, 32'h0, 0, 0, 1, 32'hCC, 32'h208, 1};
    // flush with full stage
    tbl[13] = '{1, 32'hD0, 32'h20c, 0, 0, 1, 32'hCC, 32'h208, 0};
    tbl[14] = '{1, 32'hDD, 32'h104, 1, 0, 0, 32'h0, 32'h104, 1};
    tbl[15] = '{0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h104, 1};
    // flush while empty
    tbl[16] = '{0, 32'h0, 32'h300, 1, 1, 0, 32'h0, 32'h300, 1};

    #2;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef IF_ID_STALL_CNT_EN
    chk("reset.stall_cnt", {28'b0, stall_cnt}, 32'd0);
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk_out("post_reset", 1'b0, 32'h0, 32'h0, 1'b1);

    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      instr_in  = tbl[i].ins;
      pc4_in    = tbl[i].pc;
      flush     = tbl[i].fl;
      out_ready = tbl[i].ordy;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ins,
              tbl[i].e_pc, tbl[i].e_ir);
    end
    flush = 1'b0;

    // async reset while full
    in_valid = 1'b1; instr_in = 32'hE1; pc4_in = 32'h500; out_ready = 1'b0;
    step();
    instr_in = 32'hE2; pc4_in = 32'h504;
    step();
    chk_out("full", 1'b1, 32'hE1, 32'h500, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    in_valid = 1'b1; instr_in = 32'h55; pc4_in = 32'h400; out_ready = 1'b1;
    step();
    chk_out("after_rst", 1'b1, 32'h55, 32'h400, 1'b1);

`ifdef IF_ID_STALL_CNT_EN
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("cnt_sat", {28'b0, stall_cnt}, 32'd15);
    chk_out("cnt_hold", 1'b1, 32'h55, 32'h400, 1'b1);
    flush = 1'b1; pc4_in = 32'h600;
    step();
    flush = 1'b0;
    chk("cnt_flush", {28'b0, stall_cnt}, 32'd15);
    chk_out("cnt_flush_out", 1'b0, 32'h0, 32'h600, 1'b1);
    step();
    chk("cnt_after", {28'b0, stall_cnt}, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
